// File: rtl/rf_pkg.sv
// Shared types and helpers for the 8x16 register bank and its clear engine.
package rf_pkg;

   localparam int DATA_W = 16;
   localparam int NREG   = 8;

   typedef enum logic {IDLE, CLEAR} rf_clr_state_t;

   typedef struct packed {
      logic       valid;
      logic       multi;
      logic [2:0] idx;
   } onehot_t;

   // Decode the write-decoder load vector: exactly one bit -> valid, two or more -> multi.
   function automatic onehot_t onehot_idx(input logic [NREG-1:0] wld);
      onehot_t r;
      int      cnt;
      r   = '0;
      cnt = 0;
      for (int i = 0; i < NREG; i++) begin
         if (wld[i]) begin
            cnt++;
            if (cnt == 1) r.idx = 3'(i);
         end
      end
      r.valid = (cnt == 1);
      r.multi = (cnt >= 2);
      return r;
   endfunction

endpackage

// File: rtl/reg_bank_8x16_if.sv
// Write/read/clear bus of the register bank; master drives requests, slave returns data and status.
interface reg_bank_8x16_if #(parameter int DATA_W = 16);

   logic [7:0]        wld;
   logic [DATA_W-1:0] wdata;
   logic [2:0]        ra;
   logic [2:0]        rb;
   logic              clr_start;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic              busy;
   logic              wr_drop;
   logic              err;

   modport master (output wld, wdata, ra, rb, clr_start,
                   input  rd_a, rd_b, busy, wr_drop, err);
   modport slave  (input  wld, wdata, ra, rb, clr_start,
                   output rd_a, rd_b, busy, wr_drop, err);

endinterface

// File: rtl/rf_clear_fsm.sv
// Sequential clear engine: on an accepted start, strobes one register index per cycle, 0 through 7.
module rf_clear_fsm
   import rf_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr_start,
   output logic       busy,
   output logic       clr_stb,
   output logic [2:0] clr_idx,
   output logic       start_acc
);

   rf_clr_state_t state, state_nxt;
   logic [2:0]    ptr, ptr_nxt;
   logic          busy_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         ptr   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         busy  <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      busy_nxt  = busy;
      clr_stb   = 1'b0;
      start_acc = 1'b0;
      case (state)
         IDLE: begin
            if (clr_start) begin
               start_acc = 1'b1;
               state_nxt = CLEAR;
               ptr_nxt   = '0;
               busy_nxt  = 1'b1;
            end
         end
         CLEAR: begin
            clr_stb = 1'b1;
            ptr_nxt = ptr + 3'd1;
            // Last index written this cycle; busy falls on the same edge.
            if (ptr == 3'd7) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign clr_idx = ptr;

endmodule

// File: rtl/reg_bank_8x16.sv
// 8-entry register bank with two combinational read ports and a sequential clear engine.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module reg_bank_8x16
   import rf_pkg::*;
#(
   parameter int                DATA_W    = rf_pkg::DATA_W,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter bit                R0_ZERO   = 1'b1
)(
   input  logic            clk,
   input  logic            reset_n,
   reg_bank_8x16_if.slave  bus
);

   localparam int NPORT = 2;

   logic [NREG-1:0][DATA_W-1:0]  regs;
   onehot_t                      wsel;
   logic                         busy, clr_stb, start_acc;
   logic [2:0]                   clr_idx;
   logic                         r0_hit, wr_en, drop;
   logic                         wr_drop_q, err_q;
   logic [NPORT-1:0][2:0]        raddr;
   logic [NPORT-1:0][DATA_W-1:0] rdata;

   rf_clear_fsm u_clr (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr_start (bus.clr_start),
      .busy      (busy),
      .clr_stb   (clr_stb),
      .clr_idx   (clr_idx),
      .start_acc (start_acc)
   );

   assign wsel   = onehot_idx(bus.wld);
   assign r0_hit = R0_ZERO && wsel.valid && (wsel.idx == 3'd0);
   assign wr_en  = !busy && wsel.valid && !r0_hit;
   // While clearing, any load request is discarded; in IDLE only multi-hot is.
   assign drop   = busy ? (|bus.wld) : wsel.multi;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs <= {NREG{RESET_VAL}};
      end else if (clr_stb) begin
         regs[clr_idx] <= RESET_VAL;
      end else if (wr_en) begin
         regs[wsel.idx] <= bus.wdata;
      end
   end

   // A start accepted in the same cycle as a bad load vector leaves err clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_drop_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         wr_drop_q <= drop;
         if (start_acc)       err_q <= 1'b0;
         else if (wsel.multi) err_q <= 1'b1;
      end
   end

   assign raddr[0] = bus.ra;
   assign raddr[1] = bus.rb;

   for (genvar p = 0; p < NPORT; p++) begin : g_rd
      always_comb begin
         rdata[p] = regs[raddr[p]];
         if (R0_ZERO && (raddr[p] == 3'd0)) rdata[p] = RESET_VAL;
`ifdef RF_BYPASS_EN
         if (wr_en && (wsel.idx == raddr[p])) rdata[p] = bus.wdata;
`endif
      end
   end

   assign bus.rd_a    = rdata[0];
   assign bus.rd_b    = rdata[1];
   assign bus.busy    = busy;
   assign bus.wr_drop = wr_drop_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_reg_bank_8x16.sv
// Directed bench for reg_bank_8x16 with a cycle-level reference model and per-cycle compare.
module tb_reg_bank_8x16;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_err;

   reg_bank_8x16_if #(.DATA_W(16)) bus();

   reg_bank_8x16 dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: register file as an array, clear as "cycles remaining".
   logic [15:0] m_regs [8];
   int          m_clr_left;
   logic        m_err, m_drop;

   function automatic int pop8(input logic [7:0] v);
      int c = 0;
      for (int i = 0; i < 8; i++) if (v[i]) c++;
      return c;
   endfunction

   function automatic int first_idx(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
         m_clr_left = 0;
         m_err      = 1'b0;
         m_drop     = 1'b0;
      end else begin
         int p;
         p      = pop8(bus.wld);
         m_drop = 1'b0;
         if (m_clr_left > 0) begin
            m_regs[8 - m_clr_left] = 16'h0000;
            m_clr_left--;
            if (p > 0)  m_drop = 1'b1;
            if (p >= 2) m_err  = 1'b1;
         end else begin
            if (p == 1 && bus.wld != 8'h01) m_regs[first_idx(bus.wld)] = bus.wdata;
            if (p >= 2) begin
               m_drop = 1'b1;
               m_err  = 1'b1;
            end
            if (bus.clr_start) begin
               m_clr_left = 8;
               m_err      = 1'b0;
            end
         end
      end
   end

   function automatic logic [15:0] m_read(input logic [2:0] a);
      logic [15:0] v;
      v = (a == 3'd0) ? 16'h0000 : m_regs[a];
`ifdef RF_BYPASS_EN
      if (m_clr_left == 0 && pop8(bus.wld) == 1 && bus.wld != 8'h01 && first_idx(bus.wld) == int'(a))
         v = bus.wdata;
`endif
      return v;
   endfunction

   always @(negedge clk) begin
      chk("cyc_rd_a",    32'(bus.rd_a),    32'(m_read(bus.ra)));
      chk("cyc_rd_b",    32'(bus.rd_b),    32'(m_read(bus.rb)));
      chk("cyc_busy",    32'(bus.busy),    32'(m_clr_left > 0));
      chk("cyc_wr_drop", 32'(bus.wr_drop), 32'(m_drop));
      chk("cyc_err",     32'(bus.err),     32'(m_err));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          cnt;
      logic        seen_drop;
      logic [15:0] exp_bp;
      n_chk = 0;
      n_err = 0;
      reset_n       = 1'b0;
      bus.wld       = '0;
      bus.wdata     = '0;
      bus.ra        = '0;
      bus.rb        = '0;
      bus.clr_start = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      tick();

      // 1. reset state
      for (int i = 0; i < 8; i++) begin
         bus.ra = 3'(i);
         #1 chk("reset_reg", 32'(bus.rd_a), 32'h0000);
      end
      chk("reset_busy", 32'(bus.busy), 0);
      chk("reset_err",  32'(bus.err),  0);

      // 2. write then read; same-cycle read depends on forwarding
      bus.wld = 8'h08; bus.wdata = 16'hBEEF; bus.ra = 3'd3;
`ifdef RF_BYPASS_EN
      exp_bp = 16'hBEEF;
`else
      exp_bp = 16'h0000;
`endif
      #1 chk("same_cycle_rd", 32'(bus.rd_a), 32'(exp_bp));
      tick();
      bus.wld = '0;
      #1 chk("write_read", 32'(bus.rd_a), 32'hBEEF);

      // 3. register 0 is read-only
      bus.wld = 8'h01; bus.wdata = 16'h1234; bus.rb = 3'd0;
      tick();
      bus.wld = '0;
      #1 chk("r0_read", 32'(bus.rd_b), 32'h0000);
      chk("r0_no_drop", 32'(bus.wr_drop), 0);

      // 4. multi-hot load vector
      bus.wld = 8'h0C; bus.wdata = 16'hFFFF;
      tick();
      bus.wld = '0; bus.ra = 3'd2; bus.rb = 3'd3;
      #1 chk("multi_drop", 32'(bus.wr_drop), 1);
      chk("multi_err",  32'(bus.err),  1);
      chk("multi_reg2", 32'(bus.rd_a), 32'h0000);
      chk("multi_reg3", 32'(bus.rd_b), 32'hBEEF);
      tick();
      chk("drop_1cyc", 32'(bus.wr_drop), 0);
      chk("err_held",  32'(bus.err),     1);

      // 5. clear sequence with dropped write and ignored restart
      for (int i = 1; i < 8; i++) begin
         bus.wld = 8'(1 << i); bus.wdata = 16'hA5A5;
         tick();
      end
      bus.wld = '0; bus.ra = 3'd5;
      #1 chk("preload_r5", 32'(bus.rd_a), 32'hA5A5);
      bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      chk("clr_busy", 32'(bus.busy), 1);
      chk("clr_err",  32'(bus.err),  0);
      cnt = 0; seen_drop = 1'b0;
      while (bus.busy && cnt < 20) begin
         cnt++;
         if (cnt == 3) begin bus.wld = 8'h20; bus.wdata = 16'h5555; end
         if (cnt == 5) bus.clr_start = 1'b1;
         tick();
         bus.wld = '0; bus.clr_start = 1'b0;
         if (bus.wr_drop) seen_drop = 1'b1;
      end
      chk("busy_cycles", 32'(cnt), 8);
      chk("busy_drop",   32'(seen_drop), 1);
      for (int i = 0; i < 8; i++) begin
         bus.ra = 3'(i);
         #1 chk("cleared_reg", 32'(bus.rd_a), 32'h0000);
      end
      tick();
      chk("idle_after_clr", 32'(bus.busy), 0);

      // 6. reset in the middle of a clear
      bus.wld = 8'h10; bus.wdata = 16'h1111;
      tick();
      bus.wld = '0; bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      tick(); tick();
      reset_n = 1'b0;
      bus.ra = 3'd4;
      #1 chk("rst_mid_busy", 32'(bus.busy), 0);
      chk("rst_mid_r4", 32'(bus.rd_a), 32'h0000);
      tick();
      reset_n = 1'b1;
      tick();
      bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      chk("restart_busy", 32'(bus.busy), 1);
      bus.wld = 8'h03;
      tick();
      bus.wld = '0;
      chk("busy_multi_err", 32'(bus.err), 1);
      for (int i = 0; i < 10; i++) tick();
      chk("final_idle", 32'(bus.busy), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
